// File: rtl/video_fb_pkg.sv
// Shared definitions for the frame-buffer reader: Wishbone cycle-type codes,
// FSM state encoding and the layout of one pixel word.
package video_fb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PAUSE
   } fsm_state_t;

   // One 32-bit word carries one pixel; the top byte is padding.
   typedef struct packed {
      logic [7:0] pad;
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } pixel_word_t;

endpackage

// File: rtl/wshb_frame_reader_if.sv
// Wishbone read-master bus bundle between the frame reader and the SDRAM
// controller; master drives the request, slave returns ack/err/data.
interface wshb_frame_reader_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic [31:0] dat_sm;

   modport master (
      output cyc, stb, we, sel, adr, cti, bte,
      input  ack, err, dat_sm
   );

   modport slave (
      input  cyc, stb, we, sel, adr, cti, bte,
      output ack, err, dat_sm
   );

endinterface

// File: rtl/fb_addr_gen.sv
// Word index and burst beat counters for the frame reader, producing the
// byte address of the current word and the last-word / last-beat flags.
module fb_addr_gen #(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          BEATS     = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        restart,
   input  logic        advance,
   input  logic        abort,
   output logic [31:0] adr,
   output logic        last_word,
   output logic        last_beat
);

   localparam int NWORDS = HDISP * VDISP;
   localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [IW-1:0] LAST_IDX  = IW'(NWORDS - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   logic [IW-1:0] word_idx;
   logic [BW-1:0] beat;

   // Restart beats everything; an aborted burst only rewinds the beat count,
   // so the next burst begins at the word that failed.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         word_idx <= '0;
         beat     <= '0;
      end else if (restart) begin
         word_idx <= '0;
         beat     <= '0;
      end else if (advance) begin
         word_idx <= word_idx + IW'(1);
         beat     <= last_beat ? '0 : beat + BW'(1);
      end else if (abort) begin
         beat     <= '0;
      end
   end

   assign last_word = (word_idx == LAST_IDX);
   assign last_beat = (beat == LAST_BEAT) || last_word;
   assign adr       = BASE_ADDR + (32'(word_idx) << 2);

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone read master streaming one frame from SDRAM into the pixel FIFO.
// Define FB_BURST_EN for incrementing bursts of BURST_LEN beats instead of classic cycles.
module wshb_frame_reader
   import video_fb_pkg::*;
#(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          BURST_LEN = 8
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic                       frame_start,
   wshb_frame_reader_if.master        wshb,
   output logic [31:0]                fifo_wdata,
   output logic                       fifo_write,
   input  logic                       fifo_afull,
   output logic                       frame_done,
   output logic                       frame_late,
   output logic [7:0]                 err_count
);

`ifdef FB_BURST_EN
   localparam bit BURST_MODE = 1'b1;
`else
   localparam bit BURST_MODE = 1'b0;
`endif

   localparam int BEATS = BURST_MODE ? BURST_LEN : 1;

   fsm_state_t  state;
   logic        cyc_q;
   logic        stb_q;
   pixel_word_t pixel_q;
   logic        ack_hit;
   logic        err_hit;
   logic        last_word;
   logic        last_beat;
   logic [31:0] adr;

   assign ack_hit = stb_q && wshb.ack;
   assign err_hit = stb_q && !wshb.ack && wshb.err;

   fb_addr_gen #(
      .HDISP     (HDISP),
      .VDISP     (VDISP),
      .BASE_ADDR (BASE_ADDR),
      .BEATS     (BEATS)
   ) u_addr_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .restart   (frame_start),
      .advance   (ack_hit),
      .abort     (err_hit),
      .adr       (adr),
      .last_word (last_word),
      .last_beat (last_beat)
   );

   // A frame_start mid-frame abandons the word in flight (even if acked) and
   // leaves stb low for one cycle before fetching from word 0 again; the only
   // exception is when it lands on the final ack, which completes normally.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= IDLE;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         pixel_q    <= '0;
         fifo_write <= 1'b0;
         frame_done <= 1'b0;
         frame_late <= 1'b0;
         err_count  <= '0;
      end else begin
         fifo_write <= 1'b0;
         frame_done <= 1'b0;
         frame_late <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  state <= FETCH;
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
               end
            end
            FETCH: begin
               if (frame_start && !(ack_hit && last_word)) begin
                  frame_late <= 1'b1;
                  cyc_q      <= 1'b0;
                  stb_q      <= 1'b0;
               end else if (!stb_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
               end else if (ack_hit) begin
                  fifo_write <= 1'b1;
                  pixel_q    <= wshb.dat_sm;
                  if (last_word) begin
                     frame_done <= 1'b1;
                     if (!frame_start) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                     end
                  end else if (last_beat && fifo_afull) begin
                     state <= PAUSE;
                     cyc_q <= 1'b0;
                     stb_q <= 1'b0;
                  end
               end else if (err_hit) begin
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'd1;
                  end
                  if (BURST_MODE) begin
                     cyc_q <= 1'b0;
                     stb_q <= 1'b0;
                  end
               end
            end
            PAUSE: begin
               if (frame_start) begin
                  frame_late <= 1'b1;
                  state      <= FETCH;
               end else if (!fifo_afull) begin
                  state <= FETCH;
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // In burst mode the cycle type follows the beat counter; the final beat of
   // each burst (including a truncated last burst) is flagged end-of-burst.
   always_comb begin
      wshb.cti = CTI_CLASSIC;
      if (BURST_MODE && stb_q) begin
         wshb.cti = last_beat ? CTI_EOB : CTI_INCR;
      end
   end

   assign wshb.cyc   = cyc_q;
   assign wshb.stb   = stb_q;
   assign wshb.we    = 1'b0;
   assign wshb.sel   = 4'hF;
   assign wshb.bte   = 2'b00;
   assign wshb.adr   = adr;
   assign fifo_wdata = pixel_q;

endmodule
